// File: rtl/ps2_rx_if.sv
// Read-side bundle of the PS/2 receiver: FIFO head, pop handshake and sticky error flags.
// The design uses the slave modport; the consumer (CPU side) uses master.
interface ps2_rx_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ack;
  logic       err_clr;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;

  modport master (
    input  rd_data, rd_valid, parity_err, framing_err, overflow,
    output rd_ack, err_clr
  );

  modport slave (
    output rd_data, rd_valid, parity_err, framing_err, overflow,
    input  rd_ack, err_clr
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the device clock, deserialises
// start/8 data/odd parity/stop frames and buffers good bytes in a small FIFO.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50350,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_rx_if.slave rd_if
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic              clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic              filt_clk_q, filt_clk_d;
  logic [FCNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              strobe;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TCNT_W-1:0] tmo_q, tmo_d;
  logic              push, set_par, set_frm;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              pop, full, wr_en;

  logic              par_err_q, par_err_d, frm_err_q, frm_err_d, ovf_q, ovf_d;

  // The filtered clock only follows the synchronised clock after FILTER_LEN agreeing samples.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FCNT_W'(FILTER_LEN - 1)) filt_clk_d = clk_s2_q;
      else filt_cnt_d = filt_cnt_q + FCNT_W'(1);
    end
  end

  assign strobe = filt_clk_q & ~filt_clk_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push      = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    tmo_d     = (state_q == IDLE || strobe) ? '0 : tmo_q + TCNT_W'(1);
    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (!data_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = data_s2_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s2_q;
          state_d = STOP;
        end
        STOP: begin
          // A bad stop bit is reported in preference to a parity error.
          if (!data_s2_q)              set_frm = 1'b1;
          else if (^{shift_q, par_q})  push    = 1'b1;
          else                         set_par = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      set_frm = 1'b1;
    end
  end

  assign pop     = rd_if.rd_ack && (count_q != '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign wr_en   = push && (!full || pop);
  assign rd_next = rd_ptr_q + PTR_W'(1);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = shift_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
    // rd_data is a register, so it is preloaded with whatever becomes the head next cycle.
    rd_data_d = rd_data_q;
    if (pop) begin
      if (count_q > CNT_W'(1)) rd_data_d = mem_q[rd_next];
      else if (wr_en)          rd_data_d = shift_q;
    end else if (count_q == '0 && wr_en) begin
      rd_data_d = shift_q;
    end
  end

  // Set events take priority over err_clr.
  always_comb begin
    par_err_d = set_par | (par_err_q & ~rd_if.err_clr);
    frm_err_d = set_frm | (frm_err_q & ~rd_if.err_clr);
    ovf_d     = (push && full && !pop) | (ovf_q & ~rd_if.err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_if.rd_data     = rd_data_q;
  assign rd_if.rd_valid    = (count_q != '0);
  assign rd_if.parity_err  = par_err_q;
  assign rd_if.framing_err = frm_err_q;
  assign rd_if.overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames, keeps a byte scoreboard and FIFO
// occupancy model, and checks data, latency and sticky flags.
module tb_ps2_rx;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 200;
  localparam int DEPTH      = 4;
  localparam int HALF       = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk_line = 1'b1;
  logic ps2_data_line = 1'b1;

  ps2_rx_if bus ();

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk_line),
    .ps2_data (ps2_data_line),
    .rd_if    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int model_count = 0;
  logic [7:0] exp_q [$];

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic p, input logic f, input logic o);
    check_bit({tag, "_par"}, bus.parity_err, p);
    check_bit({tag, "_frm"}, bus.framing_err, f);
    check_bit({tag, "_ovf"}, bus.overflow, o);
  endtask

  // Compare the head against the scoreboard and raise rd_ack for the current cycle.
  task automatic begin_ack(input string tag);
    logic [7:0] exp;
    exp = 8'hxx;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check_bit({tag, "_valid"}, bus.rd_valid, 1'b1);
    check_byte({tag, "_data"}, bus.rd_data, exp);
    if (model_count > 0) model_count--;
    bus.rd_ack = 1'b1;
  endtask

  task automatic read_byte(input string tag);
    begin_ack(tag);
    tick(1);
    bus.rd_ack = 1'b0;
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ps2_data_line = b;
    tick(HALF);
    ps2_clk_line = 1'b0;
    tick(HALF);
    ps2_clk_line = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_bit,
                            input logic ack_stop, input logic check_lat);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    ps2_data_line = stop_bit;
    tick(HALF);
    ps2_clk_line = 1'b0;
    // Two synchroniser stages plus FILTER_LEN-1 counts put us in the stop strobe cycle.
    tick(FILTER_LEN + 1);
    if (check_lat) check_bit("lat_strobe_valid", bus.rd_valid, 1'b0);
    if (ack_stop) begin_ack("ack_on_stop");
    tick(1);
    bus.rd_ack = 1'b0;
    if (check_lat) begin
      check_bit("lat_next_valid", bus.rd_valid, 1'b1);
      check_byte("lat_next_data", bus.rd_data, d);
    end
    tick(HALF - FILTER_LEN - 2);
    ps2_clk_line = 1'b1;
    ps2_data_line = 1'b1;
    tick(HALF);
    if (stop_bit && !bad_par && model_count < DEPTH) begin
      exp_q.push_back(d);
      model_count++;
    end
  endtask

  initial begin
    bus.rd_ack = 1'b0;
    bus.err_clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check_bit("reset_valid", bus.rd_valid, 1'b0);
    check_byte("reset_data", bus.rd_data, 8'h00);
    check_flags("reset", 1'b0, 1'b0, 1'b0);

    $display("[TB] basic frame and latency");
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
    check_flags("t1", 1'b0, 1'b0, 1'b0);
    read_byte("t1_read");
    check_bit("t1_empty", bus.rd_valid, 1'b0);

    $display("[TB] parity error");
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    check_flags("t2", 1'b1, 1'b0, 1'b0);
    check_bit("t2_valid", bus.rd_valid, 1'b0);
    pulse_err_clr();
    check_bit("t2_clr", bus.parity_err, 1'b0);

    $display("[TB] short clock glitch");
    ps2_data_line = 1'b0;
    ps2_clk_line = 1'b0;
    tick(FILTER_LEN - 1);
    ps2_clk_line = 1'b1;
    ps2_data_line = 1'b1;
    tick(30);
    check_bit("t3_valid", bus.rd_valid, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_flags("t3", 1'b0, 1'b0, 1'b0);
    read_byte("t3_read");

    $display("[TB] overflow");
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    check_flags("t4", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) read_byte("t4_read");
    check_bit("t4_empty", bus.rd_valid, 1'b0);
    pulse_err_clr();
    check_bit("t4_clr", bus.overflow, 1'b0);

    $display("[TB] inter-bit timeout");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_data_line = 1'b1;
    tick(100);
    check_bit("t5_early", bus.framing_err, 1'b0);
    tick(100);
    check_bit("t5_timeout", bus.framing_err, 1'b1);
    check_bit("t5_valid", bus.rd_valid, 1'b0);
    pulse_err_clr();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    check_flags("t5_after", 1'b0, 1'b0, 1'b0);
    read_byte("t5_read");

    $display("[TB] bad stop outranks bad parity");
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    check_flags("stop", 1'b0, 1'b1, 1'b0);
    check_bit("stop_valid", bus.rd_valid, 1'b0);
    pulse_err_clr();

    $display("[TB] push and pop together while full");
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h15, 1'b0, 1'b1, 1'b1, 1'b0);
    check_flags("t6", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) read_byte("t6_read");
    check_bit("t6_empty", bus.rd_valid, 1'b0);

    $display("[TB] reset mid-frame");
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1, 1'b0, 1'b0);
    check_bit("t7_pre_par", bus.parity_err, 1'b1);
    check_bit("t7_pre_valid", bus.rd_valid, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data_line = 1'b1;
    tick(10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    model_count = 0;
    check_bit("t7_valid", bus.rd_valid, 1'b0);
    check_byte("t7_data", bus.rd_data, 8'h00);
    check_flags("t7", 1'b0, 1'b0, 1'b0);
    tick(HALF);
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    check_flags("t7_after", 1'b0, 1'b0, 1'b0);
    read_byte("t7_read");
    check_bit("t7_empty", bus.rd_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
